// File: rtl/mb_sequencer.sv
`timescale 1ns/1ps
// mb_sequencer
// Macroblock scheduler for the intra prediction loop (intraloop). It walks a
// frame in raster order, offering one macroblock descriptor at a time over a
// valid/ready handshake. It then waits for the intraloop to report the
// macroblock done before offering the next one. At the end of the frame it
// pulses frame_done and bumps a wrapping frame counter.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   enable            global advance enable; low freezes all state and outputs
//   frame_start       single-cycle frame request, honoured only when idle
//   abort             synchronous abort back to idle, ignores enable
//   mb_ready          intraloop accepts the offered descriptor
//   mb_done           intraloop finished the accepted macroblock
//   mb_valid          descriptor valid
//   mbnumber          raster index y*FRAME_WIDTH_MB + x
//   mb_x, mb_y        column / row of the descriptor
//   avail_*           left / top / top-left / top-right neighbour availability
//   first_mb, last_mb descriptor is the first / last macroblock of the frame
//   busy              high whenever a frame is in progress
//   frame_done        single-cycle pulse at frame completion
//   frame_count       completed frames, wraps modulo 2^FCNT_WIDTH
module mb_sequencer #(
  parameter int FRAME_WIDTH_MB  = 120,
  parameter int FRAME_HEIGHT_MB = 68,
  parameter int MBNUM_WIDTH     = 13,
  parameter int FCNT_WIDTH      = 16,
  localparam int XW = (FRAME_WIDTH_MB  > 1) ? $clog2(FRAME_WIDTH_MB)  : 1,
  localparam int YW = (FRAME_HEIGHT_MB > 1) ? $clog2(FRAME_HEIGHT_MB) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic                   abort,
  input  logic                   mb_ready,
  input  logic                   mb_done,
  output logic                   mb_valid,
  output logic [MBNUM_WIDTH-1:0] mbnumber,
  output logic [XW-1:0]          mb_x,
  output logic [YW-1:0]          mb_y,
  output logic                   avail_left,
  output logic                   avail_top,
  output logic                   avail_topleft,
  output logic                   avail_topright,
  output logic                   first_mb,
  output logic                   last_mb,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FCNT_WIDTH-1:0]  frame_count
);

  localparam longint TOTAL_MB = longint'(FRAME_WIDTH_MB) * longint'(FRAME_HEIGHT_MB);
  localparam logic [MBNUM_WIDTH-1:0] LAST_MBN = MBNUM_WIDTH'(TOTAL_MB - 1);
  localparam logic [XW-1:0] LAST_X = XW'(FRAME_WIDTH_MB - 1);

  if (FRAME_WIDTH_MB < 1 || FRAME_HEIGHT_MB < 1) begin : g_bad_size
    $error("mb_sequencer: frame dimensions must be at least 1 macroblock");
  end
  if (TOTAL_MB > (longint'(1) << MBNUM_WIDTH)) begin : g_bad_mbnum
    $error("mb_sequencer: MBNUM_WIDTH too small for FRAME_WIDTH_MB*FRAME_HEIGHT_MB");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FDONE = 2'd3
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     load;
  logic                     advance;
  logic [XW-1:0]            x_nxt;
  logic [YW-1:0]            y_nxt;
  logic [MBNUM_WIDTH-1:0]   mbn_nxt;

  // Next-state decode. Abort beats everything, including a low enable.
  // Completion in WAIT uses the registered last_mb, which always describes
  // the macroblock the intraloop is currently working on.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    if (abort) begin
      state_nxt = S_IDLE;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state_nxt = S_ISSUE;
            load      = 1'b1;
          end
        end
        S_ISSUE: begin
          if (mb_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (mb_done) begin
            if (last_mb) begin
              state_nxt = S_FDONE;
            end else begin
              state_nxt = S_ISSUE;
              advance   = 1'b1;
            end
          end
        end
        S_FDONE: state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Next raster position. mbnumber is carried as its own counter so no
  // multiplier is needed to form y*W + x.
  always_comb begin
    x_nxt   = mb_x;
    y_nxt   = mb_y;
    mbn_nxt = mbnumber;
    if (load) begin
      x_nxt   = '0;
      y_nxt   = '0;
      mbn_nxt = '0;
    end else if (advance) begin
      mbn_nxt = mbnumber + MBNUM_WIDTH'(1);
      if (mb_x == LAST_X) begin
        x_nxt = '0;
        y_nxt = mb_y + YW'(1);
      end else begin
        x_nxt = mb_x + XW'(1);
      end
    end
  end

  // State, descriptor and frame counter. Availability and first/last flags
  // are derived from the next coordinates so they register in the same
  // cycle as the coordinates and the descriptor is coherent when offered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      mbnumber       <= '0;
      mb_x           <= '0;
      mb_y           <= '0;
      avail_left     <= 1'b0;
      avail_top      <= 1'b0;
      avail_topleft  <= 1'b0;
      avail_topright <= 1'b0;
      first_mb       <= 1'b0;
      last_mb        <= 1'b0;
      frame_count    <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        mbnumber       <= '0;
        mb_x           <= '0;
        mb_y           <= '0;
        avail_left     <= 1'b0;
        avail_top      <= 1'b0;
        avail_topleft  <= 1'b0;
        avail_topright <= 1'b0;
        first_mb       <= 1'b0;
        last_mb        <= 1'b0;
      end else if (load || advance) begin
        mbnumber       <= mbn_nxt;
        mb_x           <= x_nxt;
        mb_y           <= y_nxt;
        avail_left     <= (x_nxt != '0);
        avail_top      <= (y_nxt != '0);
        avail_topleft  <= (x_nxt != '0) && (y_nxt != '0);
        avail_topright <= (y_nxt != '0) && (x_nxt != LAST_X);
        first_mb       <= (mbn_nxt == '0);
        last_mb        <= (mbn_nxt == LAST_MBN);
      end
      if (!abort && enable && state == S_FDONE) begin
        frame_count <= frame_count + FCNT_WIDTH'(1);
      end
    end
  end

  // frame_done is qualified by enable so a frame completion held off by a
  // low enable still produces exactly one pulse, in the cycle it retires.
  always_comb begin
    mb_valid   = (state == S_ISSUE);
    busy       = (state != S_IDLE);
    frame_done = (state == S_FDONE) && enable && !abort;
  end

endmodule

// File: tb/tb_mb_sequencer.sv
`timescale 1ns/1ps
// tb_mb_sequencer
// Drives three sequencer instances (4x3, default 120x68, and 1x1 with a
// 2-bit frame counter) one at a time through a shared set of inputs. Expected
// descriptors are queued as each macroblock is issued. A monitor pops and
// compares them whenever the selected instance hands a descriptor over.
module tb_mb_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       abort;
  logic       mb_ready;
  logic       mb_done;
  logic [2:0] frame_start;

  always #5 clk = ~clk;

  // Instance A: 4x3 frame
  logic        a_valid, a_l, a_t, a_tl, a_tr, a_first, a_last, a_busy, a_fd;
  logic [12:0] a_mbn;
  logic [1:0]  a_x, a_y;
  logic [15:0] a_fc;

  mb_sequencer #(.FRAME_WIDTH_MB(4), .FRAME_HEIGHT_MB(3)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start[0]),
    .abort(abort), .mb_ready(mb_ready), .mb_done(mb_done), .mb_valid(a_valid),
    .mbnumber(a_mbn), .mb_x(a_x), .mb_y(a_y), .avail_left(a_l), .avail_top(a_t),
    .avail_topleft(a_tl), .avail_topright(a_tr), .first_mb(a_first),
    .last_mb(a_last), .busy(a_busy), .frame_done(a_fd), .frame_count(a_fc));

  // Instance B: default 120x68 frame
  logic        b_valid, b_l, b_t, b_tl, b_tr, b_first, b_last, b_busy, b_fd;
  logic [12:0] b_mbn;
  logic [6:0]  b_x, b_y;
  logic [15:0] b_fc;

  mb_sequencer dut_b (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start[1]),
    .abort(abort), .mb_ready(mb_ready), .mb_done(mb_done), .mb_valid(b_valid),
    .mbnumber(b_mbn), .mb_x(b_x), .mb_y(b_y), .avail_left(b_l), .avail_top(b_t),
    .avail_topleft(b_tl), .avail_topright(b_tr), .first_mb(b_first),
    .last_mb(b_last), .busy(b_busy), .frame_done(b_fd), .frame_count(b_fc));

  // Instance C: single-macroblock frame, 2-bit frame counter
  logic        c_valid, c_l, c_t, c_tl, c_tr, c_first, c_last, c_busy, c_fd;
  logic [12:0] c_mbn;
  logic [0:0]  c_x, c_y;
  logic [1:0]  c_fc;

  mb_sequencer #(.FRAME_WIDTH_MB(1), .FRAME_HEIGHT_MB(1), .FCNT_WIDTH(2)) dut_c (
    .clk(clk), .reset(reset), .enable(enable), .frame_start(frame_start[2]),
    .abort(abort), .mb_ready(mb_ready), .mb_done(mb_done), .mb_valid(c_valid),
    .mbnumber(c_mbn), .mb_x(c_x), .mb_y(c_y), .avail_left(c_l), .avail_top(c_t),
    .avail_topleft(c_tl), .avail_topright(c_tr), .first_mb(c_first),
    .last_mb(c_last), .busy(c_busy), .frame_done(c_fd), .frame_count(c_fc));

  // Selected-instance view. Descriptor layout:
  // [32:20] mbnumber, [19:13] x, [12:6] y, [5:0] left,top,topleft,topright,first,last
  int          sel;
  logic        v_valid, v_busy, v_fd;
  logic [32:0] v_desc;
  logic [15:0] v_fc;

  always_comb begin
    case (sel)
      0: begin
        v_valid = a_valid; v_busy = a_busy; v_fd = a_fd; v_fc = a_fc;
        v_desc  = {a_mbn, 5'b0, a_x, 5'b0, a_y, a_l, a_t, a_tl, a_tr, a_first, a_last};
      end
      2: begin
        v_valid = c_valid; v_busy = c_busy; v_fd = c_fd; v_fc = {14'b0, c_fc};
        v_desc  = {c_mbn, 6'b0, c_x, 6'b0, c_y, c_l, c_t, c_tl, c_tr, c_first, c_last};
      end
      default: begin
        v_valid = b_valid; v_busy = b_busy; v_fd = b_fd; v_fc = b_fc;
        v_desc  = {b_mbn, b_x, b_y, b_l, b_t, b_tl, b_tr, b_first, b_last};
      end
    endcase
  end

  logic [32:0] sbq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          fdCount     = 0;
  int          expFc[3]    = '{0, 0, 0};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference descriptor for macroblock n of a w x h frame, from div/mod.
  function automatic logic [32:0] expDesc(input int n, input int w, input int h);
    int x;
    int y;
    x = n % w;
    y = n / w;
    return {13'(n), 7'(x), 7'(y), x > 0, y > 0, (x > 0) && (y > 0),
            (y > 0) && (x < w - 1), n == 0, n == w * h - 1};
  endfunction

  function automatic logic [15:0] expFcVal(input int s);
    return 16'(expFc[s] % ((s == 2) ? 4 : 65536));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake pops one expected descriptor.
  always @(negedge clk) begin
    if (!reset && v_valid && mb_ready && enable && !abort) begin
      if (sbq.size() == 0) checkOutput("sb_underflow", 64'd1, 64'd0);
      else checkOutput("sb_desc", 64'(v_desc), 64'(sbq.pop_front()));
    end
    if (!reset && v_fd) fdCount++;
  end

  // Runs one frame on the selected instance. Index arguments of -1 disable
  // the corresponding disturbance.
  task automatic applyStimulus(input int w, input int h, input int doneDly,
                               input int stallAt, input int bothAt, input int enWaitAt,
                               input bit enFdone, input int abortAt, input int midStartAt);
    int  fdBefore;
    bit  aborted;
    fdBefore = fdCount;
    aborted  = 1'b0;
    frame_start[sel] = 1'b1;
    step();
    frame_start = '0;
    for (int n = 0; n < w * h; n++) begin
      sbq.push_back(expDesc(n, w, h));
      checkOutput("valid_latency", 64'(v_valid), 64'd1);
      if (w == 4 && n == 4) checkOutput("mb4_xy_avail", 64'({v_desc[19:6], v_desc[5:2]}), 64'({7'd0, 7'd1, 4'b0101}));
      if (w == 4 && n == 7) checkOutput("mb7_xy_avail", 64'({v_desc[19:6], v_desc[5:2]}), 64'({7'd3, 7'd1, 4'b1110}));
      if (w == 120 && n == 8159) checkOutput("last_mbn_xy", 64'(v_desc[32:6]), 64'({13'd8159, 7'd119, 7'd67}));
      if (n == stallAt) begin
        repeat (5) begin
          @(negedge clk);
          checkOutput("stall_desc", 64'({v_valid, v_desc}), 64'({1'b1, expDesc(n, w, h)}));
          step();
        end
      end
      mb_ready = 1'b1;
      if (n == bothAt) mb_done = 1'b1;
      step();
      mb_ready = 1'b0;
      mb_done  = 1'b0;
      checkOutput("accept_drop", 64'(v_valid), 64'd0);
      if (n == bothAt) begin
        step();
        checkOutput("done_not_captured", 64'({v_valid, v_busy}), 64'({1'b0, 1'b1}));
      end
      if (n == abortAt) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_clear", 64'({v_busy, v_valid, v_fd, v_desc}), 64'd0);
        checkOutput("abort_fcount", 64'(v_fc), 64'(expFcVal(sel)));
        aborted = 1'b1;
        break;
      end
      if (n == enWaitAt) begin
        enable  = 1'b0;
        mb_done = 1'b1;
        repeat (3) begin
          @(negedge clk);
          checkOutput("enable_low_wait", 64'({v_busy, v_valid, v_desc}), 64'({2'b10, expDesc(n, w, h)}));
          @(posedge clk);
        end
        #1;
        enable  = 1'b1;
        mb_done = 1'b0;
        checkOutput("enable_low_done_ignored", 64'(v_valid), 64'd0);
      end
      repeat (doneDly) step();
      checkOutput("hold_until_done", 64'({v_valid, v_desc[32:20]}), 64'({1'b0, 13'(n)}));
      mb_done = 1'b1;
      if (n == midStartAt) frame_start[sel] = 1'b1;
      step();
      mb_done     = 1'b0;
      frame_start = '0;
    end
    if (!aborted) begin
      if (enFdone) begin
        enable = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkOutput("enable_low_fdone", 64'({v_fd, v_busy, v_fc}), 64'({2'b01, expFcVal(sel)}));
          @(posedge clk);
        end
        #1;
        enable = 1'b1;
      end
      @(negedge clk);
      checkOutput("frame_done_pulse", 64'(v_fd), 64'd1);
      step();
      expFc[sel]++;
      checkOutput("frame_end_idle", 64'({v_fd, v_busy, v_valid}), 64'd0);
      checkOutput("frame_count", 64'(v_fc), 64'(expFcVal(sel)));
      checkOutput("frame_done_once", 64'(fdCount - fdBefore), 64'd1);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; abort = 1'b0;
    mb_ready = 1'b0; mb_done = 1'b0; frame_start = '0; sel = 0;
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checkOutput("reset_state", 64'({v_valid, v_busy, v_fd, v_desc, v_fc}), 64'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step();

    sel = 0;
    applyStimulus(4, 3, 2, -1, -1, -1, 1'b0, -1, -1);
    applyStimulus(4, 3, 2,  5,  3, -1, 1'b0, -1, -1);
    applyStimulus(4, 3, 1, -1, -1,  8, 1'b1, -1, -1);
    applyStimulus(4, 3, 2, -1, -1, -1, 1'b0,  6, -1);
    applyStimulus(4, 3, 2, -1, -1, -1, 1'b0, -1, -1);

    sel = 1;
    applyStimulus(120, 68, 0, -1, -1, -1, 1'b0, -1, 100);
    applyStimulus(120, 68, 0, -1, -1, -1, 1'b0, -1, -1);

    sel = 2;
    repeat (5) applyStimulus(1, 1, 1, -1, -1, -1, 1'b0, -1, -1);

    // Asynchronous reset in the middle of WAIT
    frame_start[2] = 1'b1;
    step();
    frame_start = '0;
    sbq.push_back(expDesc(0, 1, 1));
    mb_ready = 1'b1;
    step();
    mb_ready = 1'b0;
    checkOutput("pre_reset_wait", 64'({v_busy, v_valid, v_fc}), 64'({2'b10, 16'd1}));
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("async_reset", 64'({v_valid, v_busy, v_fd, v_desc, v_fc}), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("sb_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
